// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU types: machine word, register index, ALU operation codes,
//   execute-stage operand source select and branch type encodings, plus
//   the 16-bit immediate sign-extension helper used for operand and
//   branch-target generation.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // ALU operation codes understood by the single-cycle ALU.
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_ADDU = 4'd10,
    ALU_SUBU = 4'd11
  } aluop_t;

  // Operand source select for the execute stage.
  typedef enum logic [1:0] {
    SRC_RT    = 2'd0,
    SRC_SIMM  = 2'd1,
    SRC_ZIMM  = 2'd2,
    SRC_SHAMT = 2'd3
  } alusrc_t;

  // Branch type; BR_RSV behaves exactly like BR_NONE.
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2,
    BR_RSV  = 2'd3
  } br_t;

  function automatic word_t sext_imm(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// alu_operand_mux
//   Combinational operand selection and immediate extension feeding the ALU.
// Ports
//   alusrc   in   operand source select (alusrc_t)
//   rs_data  in   rs register value
//   rt_data  in   rt register value
//   imm      in   16-bit instruction immediate
//   shamt    in   5-bit shift amount
//   port_a   out  ALU operand A
//   port_b   out  ALU operand B
module alu_operand_mux
  import cpu_types_pkg::*;
(
  input  alusrc_t        alusrc,
  input  word_t          rs_data,
  input  word_t          rt_data,
  input  logic [15:0]    imm,
  input  regbits_t       shamt,
  output word_t          port_a,
  output word_t          port_b
);

  // Shifts place the shift amount on A because the ALU shifts B by A[4:0].
  always_comb begin
    port_a = rs_data;
    port_b = rt_data;
    unique case (alusrc)
      SRC_RT:    begin port_a = rs_data;            port_b = rt_data;            end
      SRC_SIMM:  begin port_a = rs_data;            port_b = sext_imm(imm);      end
      SRC_ZIMM:  begin port_a = rs_data;            port_b = {16'h0000, imm};    end
      SRC_SHAMT: begin port_a = {27'b0, shamt};     port_b = rt_data;            end
      default:   begin port_a = rs_data;            port_b = rt_data;            end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute-stage driver for the single-cycle ALU (initiator side of the ALU
//   interface). Takes one decoded instruction per beat from ID over
//   valid/ready, drives the ALU combinationally, resolves BEQ/BNE from the
//   ALU zero flag and registers the outcome into a one-entry EX/MEM register.
// Configuration
//   OVERFLOW_TRAP_EN : when defined, a checked overflow on an accepted beat
//                      sets ex_exc and suppresses the register write.
//                      When undefined, ex_exc is tied to 0.
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   flush                         kill the EX/MEM entry next cycle
//   id_valid/id_ready             ID handshake
//   id_aluop..id_wsel             decoded instruction fields
//   alu_aluop/port_a/port_b       drive to ALU
//   alu_outport/zero/negative/overflow  ALU response
//   ex_valid/ex_ready             EX/MEM handshake
//   ex_result..ex_exc             registered EX/MEM entry
module alu_exec_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic        id_valid,
  output logic        id_ready,
  input  aluop_t      id_aluop,
  input  word_t       id_rs_data,
  input  word_t       id_rt_data,
  input  logic [15:0] id_imm,
  input  regbits_t    id_shamt,
  input  alusrc_t     id_alusrc,
  input  br_t         id_brtype,
  input  logic        id_ovf_chk,
  input  word_t       id_pc,
  input  regbits_t    id_wsel,
  output aluop_t      alu_aluop,
  output word_t       alu_port_a,
  output word_t       alu_port_b,
  input  word_t       alu_outport,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        ex_valid,
  input  logic        ex_ready,
  output word_t       ex_result,
  output regbits_t    ex_wsel,
  output logic        ex_negative,
  output logic        ex_br_taken,
  output word_t       ex_br_target,
  output logic        ex_exc
);

  logic     transfer;
  logic     is_branch;
  logic     br_taken;
  word_t    br_target;
  regbits_t wsel_next;
  logic     exc_next;

  alu_operand_mux u_operand_mux (
    .alusrc  (id_alusrc),
    .rs_data (id_rs_data),
    .rt_data (id_rt_data),
    .imm     (id_imm),
    .shamt   (id_shamt),
    .port_a  (alu_port_a),
    .port_b  (alu_port_b)
  );

  assign alu_aluop = id_aluop;

  // A new beat may enter whenever the register is empty or is being drained.
  assign id_ready = !ex_valid || ex_ready;
  assign transfer = id_valid && id_ready;

  assign br_target = id_pc + 32'd4 + (sext_imm(id_imm) << 2);

  always_comb begin
    is_branch = 1'b0;
    br_taken  = 1'b0;
    unique case (id_brtype)
      BR_EQ:   begin is_branch = 1'b1; br_taken = alu_zero;  end
      BR_NE:   begin is_branch = 1'b1; br_taken = !alu_zero; end
      default: begin is_branch = 1'b0; br_taken = 1'b0;      end
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  // A trapped overflow keeps the wrapped result but must not write back.
  always_comb begin
    exc_next  = alu_overflow && id_ovf_chk;
    wsel_next = id_wsel;
    if (is_branch || exc_next) begin
      wsel_next = '0;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow & id_ovf_chk;

  always_comb begin
    exc_next  = 1'b0;
    wsel_next = is_branch ? regbits_t'(0) : id_wsel;
  end
`endif

  // EX/MEM register: flush wins, then capture, then drain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_valid     <= 1'b0;
      ex_result    <= '0;
      ex_wsel      <= '0;
      ex_negative  <= 1'b0;
      ex_br_taken  <= 1'b0;
      ex_br_target <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (transfer) begin
      ex_valid     <= 1'b1;
      ex_result    <= alu_outport;
      ex_wsel      <= wsel_next;
      ex_negative  <= alu_negative;
      ex_br_taken  <= br_taken;
      ex_br_target <= br_target;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_exc <= 1'b0;
    end else if (!flush && transfer) begin
      ex_exc <= exc_next;
    end
  end
`else
  logic unused_exc;
  assign unused_exc = exc_next;
  assign ex_exc     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
//   Scoreboard bench for alu_exec_stage. A behavioural ALU answers the
//   stage's drive; issued beats push hand-computed expectations into a
//   queue and a monitor pops/compares whenever an entry is consumed.
module tb_alu_exec_stage;
  import cpu_types_pkg::*;

  typedef struct {
    word_t    result;
    regbits_t wsel;
    logic     negative;
    logic     br_taken;
    word_t    br_target;
    logic     exc;
  } exp_t;

  logic        CLK, RST, flush, id_valid, id_ready, id_ovf_chk;
  aluop_t      id_aluop, alu_aluop;
  word_t       id_rs_data, id_rt_data, id_pc, alu_port_a, alu_port_b, alu_outport;
  logic [15:0] id_imm;
  regbits_t    id_shamt, id_wsel, ex_wsel;
  alusrc_t     id_alusrc;
  br_t         id_brtype;
  logic        alu_zero, alu_negative, alu_overflow;
  logic        ex_valid, ex_ready, ex_negative, ex_br_taken, ex_exc;
  word_t       ex_result, ex_br_target;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_exec_stage dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_aluop(id_aluop),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alusrc(id_alusrc), .id_brtype(id_brtype),
    .id_ovf_chk(id_ovf_chk), .id_pc(id_pc), .id_wsel(id_wsel),
    .alu_aluop(alu_aluop), .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
    .alu_outport(alu_outport), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_wsel(ex_wsel), .ex_negative(ex_negative), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .ex_exc(ex_exc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural stand-in for the external single-cycle ALU.
  always_comb begin
    alu_outport  = '0;
    alu_overflow = 1'b0;
    unique case (alu_aluop)
      ALU_SLL:  alu_outport = alu_port_b << alu_port_a[4:0];
      ALU_SRL:  alu_outport = alu_port_b >> alu_port_a[4:0];
      ALU_ADD: begin
        alu_outport  = alu_port_a + alu_port_b;
        alu_overflow = (alu_port_a[31] == alu_port_b[31]) && (alu_outport[31] != alu_port_a[31]);
      end
      ALU_SUB: begin
        alu_outport  = alu_port_a - alu_port_b;
        alu_overflow = (alu_port_a[31] != alu_port_b[31]) && (alu_outport[31] != alu_port_a[31]);
      end
      ALU_AND:  alu_outport = alu_port_a & alu_port_b;
      ALU_OR:   alu_outport = alu_port_a | alu_port_b;
      ALU_XOR:  alu_outport = alu_port_a ^ alu_port_b;
      ALU_NOR:  alu_outport = ~(alu_port_a | alu_port_b);
      ALU_SLT:  alu_outport = {31'b0, $signed(alu_port_a) < $signed(alu_port_b)};
      ALU_SLTU: alu_outport = {31'b0, alu_port_a < alu_port_b};
      ALU_ADDU: alu_outport = alu_port_a + alu_port_b;
      ALU_SUBU: alu_outport = alu_port_a - alu_port_b;
      default:  alu_outport = '0;
    endcase
    alu_zero     = (alu_outport == '0);
    alu_negative = alu_outport[31];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: an entry is consumed on the edge after ex_valid && ex_ready.
  always @(negedge CLK) begin
    if (!RST && ex_valid && ex_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_entry", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("ex_result",    ex_result,    e.result);
        checkOutput("ex_wsel",      32'(ex_wsel), 32'(e.wsel));
        checkOutput("ex_negative",  32'(ex_negative), 32'(e.negative));
        checkOutput("ex_br_taken",  32'(ex_br_taken), 32'(e.br_taken));
        checkOutput("ex_br_target", ex_br_target, e.br_target);
        checkOutput("ex_exc",       32'(ex_exc),  32'(e.exc));
      end
    end
  end

  task automatic setBeat(input aluop_t op, input word_t rs, input word_t rt, input logic [15:0] imm,
                         input regbits_t shamt, input alusrc_t src, input br_t br, input logic ovf,
                         input word_t pc, input regbits_t wsel);
    id_aluop = op; id_rs_data = rs; id_rt_data = rt; id_imm = imm; id_shamt = shamt;
    id_alusrc = src; id_brtype = br; id_ovf_chk = ovf; id_pc = pc; id_wsel = wsel;
  endtask

  // Presents the current id_* fields until accepted, then records the expectation.
  task automatic applyStimulus(input exp_t e);
    int waited;
    waited = 0;
    id_valid = 1'b1;
    @(negedge CLK);
    while (!id_ready && waited < 20) begin
      waited++;
      @(negedge CLK);
    end
    if (!id_ready) begin
      checkOutput("id_ready_timeout", 32'(id_ready), 32'd1);
    end else begin
      sb.push_back(e);
    end
    @(posedge CLK);
    #1 id_valid = 1'b0;
  endtask

  function automatic exp_t mk(input word_t r, input regbits_t w, input logic n, input logic t,
                              input word_t tgt, input logic x);
    exp_t e;
    e.result = r; e.wsel = w; e.negative = n; e.br_taken = t; e.br_target = tgt; e.exc = x;
    return e;
  endfunction

  initial begin
    int waited;
    RST = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    setBeat(ALU_ADD, 0, 0, 16'h0, 5'd0, SRC_RT, BR_NONE, 1'b0, 0, 5'd0);
    #2;
    checkOutput("rst_ex_valid",     32'(ex_valid), 32'd0);
    checkOutput("rst_ex_result",    ex_result, 32'd0);
    checkOutput("rst_ex_br_target", ex_br_target, 32'd0);
    checkOutput("rst_ex_exc",       32'(ex_exc), 32'd0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    // ADD 7+5
    setBeat(ALU_ADD, 32'd7, 32'd5, 16'h0000, 5'd0, SRC_RT, BR_NONE, 1'b1, 32'h0, 5'd3);
    applyStimulus(mk(32'd12, 5'd3, 1'b0, 1'b0, 32'h4, 1'b0));

    // BEQ taken, target wraps back to PC
    setBeat(ALU_SUB, 32'd3, 32'd3, 16'hFFFF, 5'd0, SRC_RT, BR_EQ, 1'b0, 32'h100, 5'd7);
    applyStimulus(mk(32'd0, 5'd0, 1'b0, 1'b1, 32'h100, 1'b0));
    // BEQ not taken
    setBeat(ALU_SUB, 32'd3, 32'd4, 16'hFFFF, 5'd0, SRC_RT, BR_EQ, 1'b0, 32'h100, 5'd7);
    applyStimulus(mk(32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 32'h100, 1'b0));
    // BNE taken, target wraps past 2^32
    setBeat(ALU_SUB, 32'd1, 32'd2, 16'h0004, 5'd0, SRC_RT, BR_NE, 1'b0, 32'hFFFF_FFF0, 5'd7);
    applyStimulus(mk(32'hFFFF_FFFF, 5'd0, 1'b1, 1'b1, 32'h0000_0004, 1'b0));
    // Reserved branch type behaves as no branch
    setBeat(ALU_SUB, 32'd5, 32'd5, 16'h0001, 5'd0, SRC_RT, BR_RSV, 1'b0, 32'h40, 5'd8);
    applyStimulus(mk(32'd0, 5'd8, 1'b0, 1'b0, 32'h48, 1'b0));

    // Overflow checked
    setBeat(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 16'h0000, 5'd0, SRC_RT, BR_NONE, 1'b1, 32'h0, 5'd5);
`ifdef OVERFLOW_TRAP_EN
    applyStimulus(mk(32'h8000_0000, 5'd0, 1'b1, 1'b0, 32'h4, 1'b1));
`else
    applyStimulus(mk(32'h8000_0000, 5'd5, 1'b1, 1'b0, 32'h4, 1'b0));
`endif
    // Overflow not checked
    setBeat(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 16'h0000, 5'd0, SRC_RT, BR_NONE, 1'b0, 32'h0, 5'd6);
    applyStimulus(mk(32'h8000_0000, 5'd6, 1'b1, 1'b0, 32'h4, 1'b0));

    // SLL by shamt
    setBeat(ALU_SLL, 32'hDEAD_BEEF, 32'h1, 16'h0000, 5'd4, SRC_SHAMT, BR_NONE, 1'b0, 32'h0, 5'd2);
    applyStimulus(mk(32'h10, 5'd2, 1'b0, 1'b0, 32'h4, 1'b0));

    // Immediate extension, and ALU ports following id_* with id_valid low
    @(posedge CLK); #1;
    setBeat(ALU_ADDU, 32'd0, 32'd0, 16'h8000, 5'd0, SRC_ZIMM, BR_NONE, 1'b0, 32'h0, 5'd4);
    #1 checkOutput("port_b_zimm", alu_port_b, 32'h0000_8000);
    setBeat(ALU_ADDU, 32'd0, 32'd0, 16'h8000, 5'd0, SRC_SIMM, BR_NONE, 1'b0, 32'h0, 5'd4);
    #1 checkOutput("port_b_simm", alu_port_b, 32'hFFFF_8000);
    checkOutput("idle_ex_valid", 32'(ex_valid), 32'd0);
    applyStimulus(mk(32'hFFFF_8000, 5'd4, 1'b1, 1'b0, 32'hFFFE_0004, 1'b0));
    setBeat(ALU_ADDU, 32'd0, 32'd0, 16'h8000, 5'd0, SRC_ZIMM, BR_NONE, 1'b0, 32'h0, 5'd4);
    applyStimulus(mk(32'h0000_8000, 5'd4, 1'b0, 1'b0, 32'hFFFE_0004, 1'b0));

    // Backpressure: hold A for 3 cycles while B waits
    @(posedge CLK); #1;
    ex_ready = 1'b0;
    setBeat(ALU_ADDU, 32'h10, 32'h20, 16'h0001, 5'd0, SRC_RT, BR_NONE, 1'b0, 32'h200, 5'd9);
    applyStimulus(mk(32'h30, 5'd9, 1'b0, 1'b0, 32'h208, 1'b0));
    setBeat(ALU_OR, 32'hF0, 32'h0, 16'h000F, 5'd0, SRC_ZIMM, BR_NONE, 1'b0, 32'h204, 5'd10);
    id_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("hold_id_ready",  32'(id_ready), 32'd0);
      checkOutput("hold_ex_valid",  32'(ex_valid), 32'd1);
      checkOutput("hold_ex_result", ex_result, 32'h30);
      checkOutput("hold_ex_wsel",   32'(ex_wsel), 32'd9);
    end
    @(posedge CLK); #1;
    ex_ready = 1'b1;
    applyStimulus(mk(32'hFF, 5'd10, 1'b0, 1'b0, 32'h244, 1'b0));

    // flush in the same cycle as a transfer discards the beat
    @(posedge CLK); #1;
    setBeat(ALU_ADD, 32'd1, 32'd1, 16'h0, 5'd0, SRC_RT, BR_NONE, 1'b0, 32'h0, 5'd11);
    id_valid = 1'b1; flush = 1'b1;
    @(posedge CLK); #1;
    id_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_ex_valid", 32'(ex_valid), 32'd0);

    // RST mid-hold clears the entry immediately
    @(posedge CLK); #1;
    ex_ready = 1'b0;
    setBeat(ALU_ADD, 32'd2, 32'd2, 16'h0, 5'd0, SRC_RT, BR_NONE, 1'b0, 32'h0, 5'd12);
    applyStimulus(mk(32'd4, 5'd12, 1'b0, 1'b0, 32'h4, 1'b0));
    @(negedge CLK);
    checkOutput("prehold_ex_valid", 32'(ex_valid), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("rst_hold_ex_valid",  32'(ex_valid), 32'd0);
    checkOutput("rst_hold_ex_result", ex_result, 32'd0);
    checkOutput("rst_hold_ex_wsel",   32'(ex_wsel), 32'd0);
    sb.delete();
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1 ex_ready = 1'b1;

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      waited++;
      @(posedge CLK);
    end
    repeat (2) @(posedge CLK);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
